// File: rtl/mmio_mem_pkg.sv
// mmio_mem_pkg: shared types, defaults and channel-address helper for mmio_data_memory
package mmio_mem_pkg;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam int DEFAULT_SIZE = 16;
  function automatic int chan_addr(input logic [1023:0] addrs, input int i, input int aw);
    return int'((addrs >> (i * aw)) & ((1024'(1) << aw) - 1024'(1)));
  endfunction
endpackage

// File: rtl/mmio_mem_clear_fsm.sv
// mmio_mem_clear_fsm: post-reset sweep sequencer that zeroes every RAM entry once
module mmio_mem_clear_fsm
  import mmio_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  // walk ptr through every entry, then hand over to RUN after the last one
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    if (state_q == ST_CLEAR) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == AW'(DEPTH - 1)) begin
        state_d = ST_RUN;
        ptr_d = '0;
      end
    end
    busy = state_q == ST_CLEAR;
    clr_we = state_q == ST_CLEAR;
    clr_addr = ptr_q;
  end
  // state register; reset always restarts the sweep at entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/mmio_data_memory.sv
// mmio_data_memory: register-file RAM with memory-mapped input channels and pending flags (option: MMIO_DATA_MEMORY_SYNC_READ_EN)
module mmio_data_memory
  import mmio_mem_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE,
  parameter int DEPTH = 64,
  parameter int NUM_INPUTS = 2,
  localparam int AW = $clog2(DEPTH),
  parameter logic [NUM_INPUTS*AW-1:0] INPUT_ADDRS = {6'd29, 6'd0}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AW-1:0]              waddr,
  input  logic [SIZE-1:0]            write_data,
  input  logic                       write_en,
  input  logic [AW-1:0]              raddr,
  input  logic                       read_en,
  output logic [SIZE-1:0]            read_data,
  input  logic [NUM_INPUTS*SIZE-1:0] in_write_data,
  input  logic [NUM_INPUTS-1:0]      in_write_en,
  output logic [NUM_INPUTS*SIZE-1:0] in_read_data,
  output logic [NUM_INPUTS-1:0]      pending,
  output logic                       irq,
  output logic                       busy
);
  localparam logic [1023:0] ADDRS_EXT = 1024'(INPUT_ADDRS);
  logic [AW-1:0] ch_addr [NUM_INPUTS];
  logic [SIZE-1:0] mem_q [DEPTH];
  logic [SIZE-1:0] mem_d [DEPTH];
  logic [NUM_INPUTS-1:0] pending_q, pending_d, ch_acc;
  logic irq_q, irq_d, clr_we, run;
  logic [AW-1:0] clr_addr;
  mmio_mem_clear_fsm #(.DEPTH(DEPTH), .AW(AW)) u_fsm (
    .clk(clk), .rst(rst), .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  assign run = !busy && !rst;
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    assign ch_addr[i] = AW'(chan_addr(ADDRS_EXT, i, AW));
    assign in_read_data[i*SIZE +: SIZE] = run ? mem_q[ch_addr[i]] : '0;
  end
  // a channel write lands only if no regular write or lower-indexed channel claims its address
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ch_acc[i] = run && in_write_en[i] && !(write_en && waddr == ch_addr[i]);
      for (int j = 0; j < i; j++)
        if (in_write_en[j] && ch_addr[j] == ch_addr[i]) ch_acc[i] = 1'b0;
    end
  end
  // next RAM image: sweep clear, then channel writes, regular write wins last
  always_comb begin
    mem_d = mem_q;
    if (clr_we) mem_d[clr_addr] = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (ch_acc[i]) mem_d[ch_addr[i]] = in_write_data[i*SIZE +: SIZE];
    if (run && write_en) mem_d[waddr] = write_data;
  end
  // pending: changed-data set beats regular-write or read clears
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++)
      pending_d[i] = !run ? 1'b0
        : (ch_acc[i] && in_write_data[i*SIZE +: SIZE] != mem_q[ch_addr[i]]) ? 1'b1
        : ((write_en && waddr == ch_addr[i]) || (read_en && raddr == ch_addr[i])) ? 1'b0
        : pending_q[i];
    irq_d = |pending_d;
  end
  // RAM array plus flag registers
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      pending_q <= '0;
      irq_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q <= irq_d;
    end
  end
  assign pending = pending_q;
  assign irq = irq_q;
`ifdef MMIO_DATA_MEMORY_SYNC_READ_EN
  logic [SIZE-1:0] rd_q, rd_d;
  // registered read samples the pre-write contents
  always_comb rd_d = run ? mem_q[raddr] : '0;
  // read data register, zero through reset and sweep
  always_ff @(posedge clk) rd_q <= rst ? '0 : rd_d;
  assign read_data = rd_q;
`else
  assign read_data = run ? mem_q[raddr] : '0;
`endif
endmodule

// File: tb/tb_mmio_data_memory.sv
// tb_mmio_data_memory: scoreboard bench for mmio_data_memory
module tb_mmio_data_memory;
  localparam int SIZE = 16, DEPTH = 64, NI = 2, AW = 6;
  logic clk = 1'b0;
  logic rst, write_en, read_en, irq, busy;
  logic [AW-1:0] waddr, raddr;
  logic [SIZE-1:0] write_data, read_data;
  logic [NI*SIZE-1:0] in_write_data, in_read_data;
  logic [NI-1:0] in_write_en, pending;
  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e, g;
  int cnt;

  mmio_data_memory #(.SIZE(SIZE), .DEPTH(DEPTH), .NUM_INPUTS(NI), .INPUT_ADDRS({6'd29, 6'd0})) dut (
    .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data), .write_en(write_en),
    .raddr(raddr), .read_en(read_en), .read_data(read_data), .in_write_data(in_write_data),
    .in_write_en(in_write_en), .in_read_data(in_read_data), .pending(pending), .irq(irq), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic idle();
    write_en = 0; read_en = 0; in_write_en = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic count_busy();
    cnt = 0;
    while (busy && cnt < 200) begin tick(); cnt++; end
  endtask

  task automatic test_reset();
    rst = 1; idle(); waddr = 0; raddr = 0; write_data = 0; in_write_data = '0;
    tick();
    exp_q.push_back(32'h0008_0000);
    g = {12'd0, busy, pending, irq, read_data};
    e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL reset_state got %h exp %h", g, e); end
    rst = 0;
    exp_q.push_back(64);
    count_busy();
    e = exp_q.pop_front(); n_checks++;
    if (cnt !== e) begin n_fail++; $display("FAIL sweep_len got %0d exp %0d", cnt, e); end
    waddr = 5; write_data = 16'hBEEF; write_en = 1; raddr = 5;
    exp_q.push_back(32'hBEEF);
    tick(); idle(); tick();
    e = exp_q.pop_front(); n_checks++;
    if (32'(read_data) !== e) begin n_fail++; $display("FAIL prefill got %h exp %h", read_data, e); end
    rst = 1; tick(); rst = 0;
    exp_q.push_back(64);
    count_busy();
    e = exp_q.pop_front(); n_checks++;
    if (cnt !== e) begin n_fail++; $display("FAIL resweep_len got %0d exp %0d", cnt, e); end
    exp_q.push_back(0);
    tick();
    g = {13'd0, pending, irq, read_data};
    e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL cleared_mem got %h exp %h", g, e); end
  endtask

  task automatic test_precedence();
    waddr = 29; write_data = 16'h1111; write_en = 1; raddr = 29;
    in_write_data = {16'h2222, 16'h0000}; in_write_en = 2'b10;
    exp_q.push_back(32'h0000_1111);
    tick(); idle();
    g = {14'd0, pending, in_read_data[31:16]};
    e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL precedence got %h exp %h", g, e); end
    exp_q.push_back(32'h1111);
    tick();
    e = exp_q.pop_front(); n_checks++;
    if (32'(read_data) !== e) begin n_fail++; $display("FAIL prec_read got %h exp %h", read_data, e); end
  endtask

  task automatic test_pending();
    in_write_data = {16'h0000, 16'h0004};
    for (int k = 0; k < 2; k++) begin
      in_write_en = 2'b01;
      exp_q.push_back(32'h0003_0004);
      tick(); idle();
      g = {13'd0, pending, irq, in_read_data[15:0]};
      e = exp_q.pop_front(); n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL pend_set%0d got %h exp %h", k, g, e); end
    end
    read_en = 1; raddr = 0;
    exp_q.push_back(0);
    tick(); idle();
    g = {29'd0, pending, irq};
    e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL pend_rdclr got %h exp %h", g, e); end
    in_write_en = 2'b01;
    exp_q.push_back(32'h0000_0004);
    tick(); idle();
    g = {13'd0, pending, irq, in_read_data[15:0]};
    e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL pend_same got %h exp %h", g, e); end
  endtask

  task automatic test_collision();
    read_en = 1; raddr = 29; in_write_data = {16'h0008, 16'h0004}; in_write_en = 2'b10;
    exp_q.push_back(32'h0005_0008);
    tick(); idle();
    g = {13'd0, pending, irq, in_read_data[31:16]};
    e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL collision got %h exp %h", g, e); end
    write_en = 1; waddr = 29; write_data = 16'h0008;
    exp_q.push_back(0);
    tick(); idle();
    g = {29'd0, pending, irq};
    e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL wr_clear got %h exp %h", g, e); end
  endtask

  task automatic test_mid_reset();
    in_write_data = {16'h0055, 16'h0004}; in_write_en = 2'b10;
    tick(); idle();
    rst = 1; tick(); rst = 0;
    in_write_data = {16'h7777, 16'h6666}; in_write_en = 2'b11;
    repeat (30) tick();
    exp_q.push_back(32'h0008_0000);
    g = {12'd0, busy, pending, irq, read_data};
    e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL mid_sweep got %h exp %h", g, e); end
    rst = 1; tick(); rst = 0;
    exp_q.push_back(64);
    count_busy();
    e = exp_q.pop_front(); n_checks++;
    if (cnt !== e) begin n_fail++; $display("FAIL restart_len got %0d exp %0d", cnt, e); end
    idle();
    exp_q.push_back(0);
    #1;
    g = {in_read_data[31:16] | in_read_data[15:0], 14'd0, pending};
    e = exp_q.pop_front(); n_checks++;
    if (g !== e) begin n_fail++; $display("FAIL dropped got %h exp %h", g, e); end
  endtask

  task automatic test_same_cycle();
    waddr = 7; write_data = 16'hA5A5; write_en = 1; raddr = 7;
    exp_q.push_back(0);
    exp_q.push_back(32'hA5A5);
`ifdef MMIO_DATA_MEMORY_SYNC_READ_EN
    tick(); idle();
`else
    #1;
`endif
    e = exp_q.pop_front(); n_checks++;
    if (32'(read_data) !== e) begin n_fail++; $display("FAIL rd_old got %h exp %h", read_data, e); end
    tick(); idle();
`ifdef MMIO_DATA_MEMORY_SYNC_READ_EN
    tick();
`endif
    e = exp_q.pop_front(); n_checks++;
    if (32'(read_data) !== e) begin n_fail++; $display("FAIL rd_new got %h exp %h", read_data, e); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      waddr = AW'(40 + k); write_data = SIZE'($urandom); write_en = 1;
      exp_q.push_back(32'(write_data));
      tick();
    end
    idle();
    for (int k = 0; k < 8; k++) begin
      raddr = AW'(40 + k);
      tick();
      e = exp_q.pop_front(); n_checks++;
      if (32'(read_data) !== e) begin n_fail++; $display("FAIL b2b[%0d] got %h exp %h", k, read_data, e); end
    end
  endtask

  initial begin
    test_reset();
    test_precedence();
    test_pending();
    test_collision();
    test_mid_reset();
    test_same_cycle();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
